// File: rtl/mem_copy_engine.sv
// mem_copy_engine: byte-serial block copy initiator for the 8-bit CPU's data memory.
// Copies `length` bytes from src to dst (ascending, one read then one write per byte)
// while asserting `busy`, and accumulates an XOR checksum of every byte written.
// Optional fill mode is compiled in by defining MEM_COPY_FILL_EN; without it the
// `mode` and `fill_value` ports are accepted but ignored and every transfer is a copy.
module mem_copy_engine #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [7:0]            length,
   input  logic                  mode,
   input  logic [DATA_WIDTH-1:0] fill_value,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  MemWrite,
   output logic                  MemRead,
   input  logic [DATA_WIDTH-1:0] ReadData
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic [DATA_WIDTH-1:0] csum_q, csum_d;

   // Fill-mode view of the datapath: request seen in IDLE, latched mode and pattern.
   logic                  req_fill;
   logic                  fill_mode;
   logic [DATA_WIDTH-1:0] fill_data;
   logic [DATA_WIDTH-1:0] wr_byte;

`ifdef MEM_COPY_FILL_EN
   logic                  fill_q;
   logic [DATA_WIDTH-1:0] fill_val_q;

   assign req_fill  = mode;
   assign fill_mode = fill_q;
   assign fill_data = fill_val_q;

   // Latch fill operands on an accepted start so input changes mid-transfer are ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         fill_q     <= 1'b0;
         fill_val_q <= '0;
      end else if (state_q == StIdle && start) begin
         fill_q     <= mode;
         fill_val_q <= fill_value;
      end
   end
`else
   logic unused_fill;

   assign unused_fill = ^{mode, fill_value};
   assign req_fill    = 1'b0;
   assign fill_mode   = 1'b0;
   assign fill_data   = '0;
`endif

   // Byte written in WRITE: the pattern in fill mode, otherwise the byte just read.
   assign wr_byte  = fill_mode ? fill_data : buf_q;
   assign checksum = csum_q;

   // State, pointer, counter, buffer and checksum registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         csum_q  <= csum_d;
      end
   end

   // Next-state, datapath update and memory-side outputs (Moore, decoded from state).
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      csum_d    = csum_q;
      busy      = 1'b0;
      done      = 1'b0;
      Address   = '0;
      WriteData = '0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               src_d  = src_addr;
               dst_d  = dst_addr;
               cnt_d  = length;
               csum_d = '0;
               if (length == 8'd0) begin
                  state_d = StDone;
               end else if (req_fill) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end

         StRead: begin
            busy    = 1'b1;
            Address = src_q;
            MemRead = 1'b1;
            buf_d   = ReadData;
            src_d   = src_q + ADDR_WIDTH'(1);
            state_d = StWrite;
         end

         StWrite: begin
            busy      = 1'b1;
            Address   = dst_q;
            WriteData = wr_byte;
            MemWrite  = 1'b1;
            csum_d    = csum_q ^ wr_byte;
            dst_d     = dst_q + ADDR_WIDTH'(1);
            cnt_d     = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = StDone;
            end else if (fill_mode) begin
               state_d = StWrite;
            end else begin
               state_d = StRead;
            end
         end

         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: stimulus pushes expected memory accesses and
// done events; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_copy_engine;

`ifdef MEM_COPY_FILL_EN
   localparam bit FillEn = 1'b1;
`else
   localparam bit FillEn = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] src_addr, dst_addr, length, fill_value;
   logic       mode;
   logic       busy, done, MemWrite, MemRead;
   logic [7:0] checksum, Address, WriteData, ReadData;

   logic [7:0] mem [256];
   logic [7:0] exp_mem [256];
   logic       pl_we;
   logic [7:0] pl_addr, pl_data;
   int         cyc = 0;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } acc_t;

   typedef struct {
      int         cyc;
      logic [7:0] csum;
   } done_t;

   acc_t  acc_q[$];
   done_t done_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   logic [7:0] cs;

   mem_copy_engine #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .mode       (mode),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .checksum   (checksum),
      .Address    (Address),
      .WriteData  (WriteData),
      .MemWrite   (MemWrite),
      .MemRead    (MemRead),
      .ReadData   (ReadData)
   );

   always #5 clock = ~clock;

   // Data memory: combinational read, write on posedge; bench preload port when idle.
   assign ReadData = mem[Address];
   always @(posedge clock) begin
      if (MemWrite) mem[Address] <= WriteData;
      else if (pl_we) mem[pl_addr] <= pl_data;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every memory access and every done pulse must match the scoreboard head.
   always @(negedge clock) begin
      acc_t  ea;
      done_t ed;
      if (MemRead || MemWrite) begin
         if (acc_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_access: got addr 0x%0h wr %0b rd %0b, expected none",
                     Address, MemWrite, MemRead);
         end else begin
            ea = acc_q.pop_front();
            chk("access_is_write", 32'(MemWrite), 32'(ea.wr));
            chk("access_is_read", 32'(MemRead), 32'(!ea.wr));
            chk("access_addr", 32'(Address), 32'(ea.addr));
            if (ea.wr) chk("write_data", 32'(WriteData), 32'(ea.data));
         end
      end
      if (done) begin
         if (done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
         end else begin
            ed = done_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(ed.cyc));
            chk("done_checksum", 32'(checksum), 32'(ed.csum));
         end
      end
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clock);
      pl_we = 1'b1;
      pl_addr = a;
      pl_data = d;
      exp_mem[a] = d;
      @(negedge clock);
      pl_we = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_checksum"}, 32'(checksum), 32'd0);
      chk({tag, "_address"}, 32'(Address), 32'd0);
      chk({tag, "_wdata"}, 32'(WriteData), 32'd0);
      chk({tag, "_memwrite"}, 32'(MemWrite), 32'd0);
      chk({tag, "_memread"}, 32'(MemRead), 32'd0);
   endtask

   // Issue one transfer; abort_at>0 asserts reset during that cycle of the transfer.
   task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                           input logic m, input logic [7:0] fv, input int abort_at,
                           input bit mid_start, output logic [7:0] csum);
      acc_t       acc[$];
      logic [7:0] shadow [256];
      logic [7:0] data, sa, da;
      int         lat, start_cyc, lim;
      bit         fill;
      done_t      de;
      shadow = exp_mem;
      fill = FillEn && m;
      csum = 8'h00;
      for (int i = 0; i < int'(n); i++) begin
         sa = s + 8'(i);
         da = d + 8'(i);
         if (fill) begin
            data = fv;
         end else begin
            acc.push_back('{1'b0, sa, 8'h00});
            data = shadow[sa];
         end
         acc.push_back('{1'b1, da, data});
         shadow[da] = data;
         csum ^= data;
      end
      lat = (n == 8'd0) ? 1 : (fill ? int'(n) + 1 : 2 * int'(n) + 1);
      lim = (abort_at > 0) ? abort_at : acc.size();
      for (int j = 0; j < lim; j++) begin
         acc_q.push_back(acc[j]);
         if (acc[j].wr) exp_mem[acc[j].addr] = acc[j].data;
      end
      @(negedge clock);
      src_addr = s;
      dst_addr = d;
      length = n;
      mode = m;
      fill_value = fv;
      start = 1'b1;
      start_cyc = cyc;
      if (abort_at == 0) begin
         de.cyc = start_cyc + lat;
         de.csum = csum;
         done_q.push_back(de);
      end
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clock);
         if (k == 1) start = 1'b0;
         if (mid_start && k == 3) begin
            start = 1'b1;
            src_addr = 8'h00;
            dst_addr = 8'h00;
            length = 8'd9;
         end
         if (mid_start && k == 4) start = 1'b0;
         if (abort_at > 0 && k == abort_at + 1) begin
            chk_idle_outputs("after_reset");
            reset = 1'b0;
            break;
         end
         chk("busy", 32'(busy), 32'(k < lat));
         if (abort_at > 0 && k == abort_at) reset = 1'b1;
      end
      chk("pending_accesses", 32'(acc_q.size()), 32'd0);
      if (abort_at == 0) begin
         chk("pending_done", 32'(done_q.size()), 32'd0);
         chk("checksum_hold", 32'(checksum), 32'(csum));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mode = 1'b0;
      src_addr = 8'h00;
      dst_addr = 8'h00;
      length = 8'h00;
      fill_value = 8'h00;
      pl_we = 1'b0;
      pl_addr = 8'h00;
      pl_data = 8'h00;
      repeat (3) @(negedge clock);
      chk_idle_outputs("reset");
      reset = 1'b0;

      // Plain copy with an ignored mid-transfer start.
      preload(8'h10, 8'h11);
      preload(8'h11, 8'h22);
      preload(8'h12, 8'h33);
      preload(8'h13, 8'h44);
      run_xfer(8'h10, 8'h80, 8'd4, 1'b0, 8'h00, 0, 1'b1, cs);
      chk("copy_mem80", 32'(mem[8'h80]), 32'h11);
      chk("copy_mem81", 32'(mem[8'h81]), 32'h22);
      chk("copy_mem82", 32'(mem[8'h82]), 32'h33);
      chk("copy_mem83", 32'(mem[8'h83]), 32'h44);
      chk("copy_checksum", 32'(checksum), 32'h44);

      // Address wrap on both pointers.
      preload(8'hFE, 8'hA1);
      preload(8'hFF, 8'hA2);
      preload(8'h00, 8'hA3);
      preload(8'h01, 8'hA4);
      run_xfer(8'hFE, 8'hFD, 8'd4, 1'b0, 8'h00, 0, 1'b0, cs);
      chk("wrap_memFD", 32'(mem[8'hFD]), 32'hA1);
      chk("wrap_memFE", 32'(mem[8'hFE]), 32'hA2);
      chk("wrap_memFF", 32'(mem[8'hFF]), 32'hA3);
      chk("wrap_mem00", 32'(mem[8'h00]), 32'hA4);

      // Zero length: done in cycle 1, no access, checksum cleared.
      run_xfer(8'h30, 8'h31, 8'd0, 1'b0, 8'h00, 0, 1'b0, cs);
      chk("zero_checksum", 32'(checksum), 32'h00);

      // Forward overlap propagates the first source byte.
      preload(8'h20, 8'h5A);
      preload(8'h21, 8'h01);
      preload(8'h22, 8'h02);
      preload(8'h23, 8'h03);
      run_xfer(8'h20, 8'h21, 8'd3, 1'b0, 8'h00, 0, 1'b0, cs);
      chk("ovl_mem21", 32'(mem[8'h21]), 32'h5A);
      chk("ovl_mem22", 32'(mem[8'h22]), 32'h5A);
      chk("ovl_mem23", 32'(mem[8'h23]), 32'h5A);
      chk("ovl_checksum", 32'(checksum), 32'h5A);

      // Reset in cycle 3 of a 4-byte copy, then a 1-byte copy.
      preload(8'h60, 8'h01);
      preload(8'h61, 8'h02);
      preload(8'h62, 8'h03);
      preload(8'h63, 8'h04);
      preload(8'h91, 8'hEE);
      run_xfer(8'h60, 8'h90, 8'd4, 1'b0, 8'h00, 3, 1'b0, cs);
      chk("abort_mem90", 32'(mem[8'h90]), 32'h01);
      chk("abort_mem91", 32'(mem[8'h91]), 32'hEE);
      run_xfer(8'h60, 8'hA0, 8'd1, 1'b0, 8'h00, 0, 1'b0, cs);
      chk("post_abort_memA0", 32'(mem[8'hA0]), 32'h01);
      chk("post_abort_checksum", 32'(checksum), 32'h01);

      // Fill request; a copy from src when the fill path is not built.
      preload(8'h50, 8'h01);
      preload(8'h51, 8'h02);
      preload(8'h52, 8'h03);
      preload(8'h53, 8'h04);
      preload(8'h54, 8'h05);
      run_xfer(8'h50, 8'h40, 8'd5, 1'b1, 8'hC3, 0, 1'b0, cs);
      for (int i = 0; i < 5; i++) begin
         chk("fill_mem", 32'(mem[8'h40 + 8'(i)]), FillEn ? 32'hC3 : 32'(i + 1));
      end
      chk("fill_checksum", 32'(checksum), FillEn ? 32'hC3 : 32'h01);

      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
